move_check_dispatcher: RTL

//  Initiator side of the piece-checker handshake in board_validator.
//  - Accepts one move request, pre-screens it and computes absolute deltas.
//  - Drives the matching check_<piece> responder and waits for its result.
//  - Returns a single legal/illegal verdict with an error code to game_play.

---
 rtl/move_check_dispatcher.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/move_check_dispatcher.sv
// rtl/move_check_dispatcher.sv - move request pre-screen and piece-checker dispatch/collect
// Optional TURN_CHECK_EN: reject a move whose source colour differs from side_to_move.
module move_check_dispatcher #(
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [2:0]   i_old_x,
  input  logic [2:0]   i_old_y,
  input  logic [2:0]   i_new_x,
  input  logic [2:0]   i_new_y,
  input  logic [255:0] i_board_in,
  input  logic         i_side_to_move,
  output logic [2:0]   o_chk_old_x,
  output logic [2:0]   o_chk_old_y,
  output logic [2:0]   o_chk_new_x,
  output logic [2:0]   o_chk_new_y,
  output logic [2:0]   o_chk_h_delta,
  output logic [2:0]   o_chk_v_delta,
  output logic [3:0]   o_chk_piece_type,
  output logic [5:0]   o_chk_sel,
  output logic         o_chk_start,
  input  logic [5:0]   i_chk_valid_move,
  input  logic [5:0]   i_chk_valid_output,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_legal,
  output logic [2:0]   o_rsp_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRECHECK = 3'd1;
  localparam logic [2:0] S_DISPATCH = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_RESPOND  = 3'd4;

  localparam logic [2:0] ERR_OK         = 3'd0;
  localparam logic [2:0] ERR_SRC_EMPTY  = 3'd1;
  localparam logic [2:0] ERR_NULL_MOVE  = 3'd2;
  localparam logic [2:0] ERR_FRIENDLY   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
  localparam logic [2:0] ERR_WRONG_TURN = 3'd5;
  localparam logic [2:0] ERR_BAD_PIECE  = 3'd6;

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic          r_req_ready;
  logic [2:0]    r_old_x, r_old_y, r_new_x, r_new_y;
  logic [2:0]    r_h_delta, r_v_delta;
  logic [3:0]    r_piece;
  logic [5:0]    r_chk_sel;
  logic          r_chk_start;
  logic          r_rsp_valid;
  logic          r_rsp_legal;
  logic [2:0]    r_rsp_err;

  logic [3:0] w_src, w_dst;
  logic       w_src_black, w_dst_black;
  logic [2:0] w_class;
  logic [2:0] w_pre_err;
  logic [2:0] w_h_delta, w_v_delta;
  logic       w_sel_hit, w_sel_legal;

  // board_in is read live; the requester keeps it stable for the whole transaction
  assign w_src       = i_board_in[{r_old_y, r_old_x, 2'b00} +: 4];
  assign w_dst       = i_board_in[{r_new_y, r_new_x, 2'b00} +: 4];
  assign w_src_black = (w_src >= 4'd6);
  assign w_dst_black = (w_dst >= 4'd6);
  assign w_class     = w_src_black ? 3'(w_src - 4'd6) : w_src[2:0];
  assign w_h_delta   = (r_new_x >= r_old_x) ? (r_new_x - r_old_x) : (r_old_x - r_new_x);
  assign w_v_delta   = (r_new_y >= r_old_y) ? (r_new_y - r_old_y) : (r_old_y - r_new_y);
  assign w_sel_hit   = |(i_chk_valid_output & r_chk_sel);
  assign w_sel_legal = |(i_chk_valid_move & r_chk_sel);

`ifndef TURN_CHECK_EN
  logic w_unused_side;
  assign w_unused_side = i_side_to_move;
`endif

  always_comb begin
    w_pre_err = ERR_OK;
    if (w_src == 4'd15)
      w_pre_err = ERR_SRC_EMPTY;
    else if (w_src >= 4'd12)
      w_pre_err = ERR_BAD_PIECE;
`ifdef TURN_CHECK_EN
    else if (w_src_black != i_side_to_move)
      w_pre_err = ERR_WRONG_TURN;
`endif
    else if (r_old_x == r_new_x && r_old_y == r_new_y)
      w_pre_err = ERR_NULL_MOVE;
    else if (w_dst != 4'd15 && w_dst_black == w_src_black)
      w_pre_err = ERR_FRIENDLY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_req_ready <= 1'b1;
      r_old_x     <= '0;
      r_old_y     <= '0;
      r_new_x     <= '0;
      r_new_y     <= '0;
      r_h_delta   <= '0;
      r_v_delta   <= '0;
      r_piece     <= '0;
      r_chk_sel   <= '0;
      r_chk_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_legal <= 1'b0;
      r_rsp_err   <= ERR_OK;
    end else begin
      r_chk_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_old_x     <= i_old_x;
            r_old_y     <= i_old_y;
            r_new_x     <= i_new_x;
            r_new_y     <= i_new_y;
            r_req_ready <= 1'b0;
            r_state     <= S_PRECHECK;
          end
        end
        S_PRECHECK: begin
          r_h_delta <= w_h_delta;
          r_v_delta <= w_v_delta;
          r_piece   <= w_src;
          if (w_pre_err != ERR_OK) begin
            r_rsp_err   <= w_pre_err;
            r_rsp_legal <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else begin
            r_chk_sel   <= 6'd1 << w_class;
            r_chk_start <= 1'b1;
            r_state     <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A result on the timeout cycle still wins over the timeout
          if (r_timer >= TW'(SETTLE_CYCLES) && w_sel_hit) begin
            r_rsp_legal <= w_sel_legal;
            r_rsp_err   <= ERR_OK;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else if (r_timer == TW'(TIMEOUT_CYCLES)) begin
            r_rsp_legal <= 1'b0;
            r_rsp_err   <= ERR_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESPOND: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_chk_sel   <= '0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready      = r_req_ready;
  assign o_chk_old_x      = r_old_x;
  assign o_chk_old_y      = r_old_y;
  assign o_chk_new_x      = r_new_x;
  assign o_chk_new_y      = r_new_y;
  assign o_chk_h_delta    = r_h_delta;
  assign o_chk_v_delta    = r_v_delta;
  assign o_chk_piece_type = r_piece;
  assign o_chk_sel        = r_chk_sel;
  assign o_chk_start      = r_chk_start;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_legal      = r_rsp_legal;
  assign o_rsp_err        = r_rsp_err;

endmodule
